io_pinmux: RTL and testbench

IO_PINMUX -- requirements
Module: io_pinmux

---
 rtl/io_pinmux.sv | 145 ++++++++++++++
 tb/tb_io_pinmux.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/io_pinmux.sv
// io_pinmux: AHB-lite programmable pad mux, 4 functions per pad, zero wait states.
// Define PINMUX_LOCK_EN to build the sticky LOCK bit that freezes SEL0..SEL3 until reset.

module io_pinmux #(
   parameter int   N_PADS  = 38,
   parameter logic IN_IDLE = 1'b1
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [7:0]            HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic                  HREADY,
   input  logic [31:0]           HWDATA,
   output logic [31:0]           HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   input  logic [N_PADS-1:0]     io_in,
   output logic [N_PADS-1:0]     io_out,
   output logic [N_PADS-1:0]     io_oeb,
   input  logic [4*N_PADS-1:0]   fn_out,
   input  logic [4*N_PADS-1:0]   fn_oeb,
   output logic [4*N_PADS-1:0]   fn_in
);

   logic [N_PADS-1:0][1:0] r_sel;
   logic                   r_dp_vld;
   logic                   r_dp_write;
   logic [5:0]             r_dp_addr;
   logic [N_PADS-1:0]      r_sync1;
   logic [N_PADS-1:0]      r_sync2;

   logic                   w_addr_ph;
   logic                   w_wr_sel;
   logic                   w_wr_lock;
   logic                   w_lock;
   logic [31:0]            w_rd_dat;
   logic                   w_unused;

   assign w_addr_ph = HSEL & HREADY & HTRANS[1];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_dp_vld   <= 1'b0;
         r_dp_write <= 1'b0;
         r_dp_addr  <= '0;
      end else begin
         r_dp_vld <= w_addr_ph;
         if (w_addr_ph) begin
            r_dp_addr  <= HADDR[7:2];
            r_dp_write <= HWRITE;
         end
      end
   end

   assign w_wr_sel  = r_dp_vld & r_dp_write & (r_dp_addr[5:2] == 4'd0) & ~w_lock;
   assign w_wr_lock = r_dp_vld & r_dp_write & (r_dp_addr == 6'd4);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_sel <= '0;
      end else if (w_wr_sel) begin
         for (int i = 0; i < N_PADS; i++) begin
            if (r_dp_addr[1:0] == 2'(i / 16))
               r_sel[i] <= HWDATA[2*(i%16) +: 2];
         end
      end
   end

`ifdef PINMUX_LOCK_EN
   logic r_lock;

   // Sticky: only a reset can clear it.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         r_lock <= 1'b0;
      else if (w_wr_lock && HWDATA[0])
         r_lock <= 1'b1;
   end

   assign w_lock = r_lock;
`else
   assign w_lock = 1'b0;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= io_in;
         r_sync2 <= r_sync1;
      end
   end

   // PADIN at 0x14 carries pads 0..31; pads 32..63 continue in the word at 0x18.
   always_comb begin
      w_rd_dat = '0;
      if (r_dp_vld && !r_dp_write) begin
         if (r_dp_addr[5:2] == 4'd0) begin
            for (int i = 0; i < N_PADS; i++) begin
               if (r_dp_addr[1:0] == 2'(i / 16))
                  w_rd_dat[2*(i%16) +: 2] = r_sel[i];
            end
         end else if (r_dp_addr == 6'd4) begin
            w_rd_dat[0] = w_lock;
         end else if (r_dp_addr == 6'd5) begin
            for (int i = 0; i < N_PADS && i < 32; i++)
               w_rd_dat[i] = r_sync2[i];
         end else if (r_dp_addr == 6'd6) begin
            for (int i = 32; i < N_PADS; i++)
               w_rd_dat[i-32] = r_sync2[i];
         end
      end
   end

   assign HRDATA    = w_rd_dat;
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

   always_comb begin
      io_out = '0;
      io_oeb = '0;
      for (int i = 0; i < N_PADS; i++) begin
         case (r_sel[i])
            2'd0:    begin io_out[i] = fn_out[i];            io_oeb[i] = fn_oeb[i];            end
            2'd1:    begin io_out[i] = fn_out[N_PADS+i];     io_oeb[i] = fn_oeb[N_PADS+i];     end
            2'd2:    begin io_out[i] = fn_out[2*N_PADS+i];   io_oeb[i] = fn_oeb[2*N_PADS+i];   end
            default: begin io_out[i] = fn_out[3*N_PADS+i];   io_oeb[i] = fn_oeb[3*N_PADS+i];   end
         endcase
      end
   end

   always_comb begin
      fn_in = '0;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N_PADS; i++)
            fn_in[f*N_PADS+i] = (r_sel[i] == 2'(f)) ? io_in[i] : IN_IDLE;
      end
   end

   assign w_unused = ^{HADDR[1:0], HTRANS[0], w_wr_lock};

endmodule

// File: tb/tb_io_pinmux.sv
// Directed bench for io_pinmux: reset, function routing, back-to-back AHB, PADIN latency, lock, reset mid-write.
module tb_io_pinmux;
   localparam int N = 38;

   logic           HCLK = 1'b0;
   logic           HRESETn;
   logic           HSEL;
   logic [7:0]     HADDR;
   logic [1:0]     HTRANS;
   logic           HWRITE;
   logic           HREADY;
   logic [31:0]    HWDATA;
   logic [31:0]    HRDATA;
   logic           HREADYOUT;
   logic           HRESP;
   logic [N-1:0]   io_in;
   logic [N-1:0]   io_out;
   logic [N-1:0]   io_oeb;
   logic [4*N-1:0] fn_out;
   logic [4*N-1:0] fn_oeb;
   logic [4*N-1:0] fn_in;

   int             total = 0;
   int             bad   = 0;
   logic [1:0]     m_sel [N];
   logic [31:0]    rd;
   logic [159:0]   rnd;

   always #5 HCLK = ~HCLK;

   io_pinmux #(.N_PADS(N), .IN_IDLE(1'b1)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .io_in(io_in), .io_out(io_out),
      .io_oeb(io_oeb), .fn_out(fn_out), .fn_oeb(fn_oeb), .fn_in(fn_in)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] exp_pad(input logic [4*N-1:0] f);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i] = f[int'(m_sel[i])*N + i];
      return r;
   endfunction

   task automatic idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 8'h00; HREADY = 1'b1;
   endtask

   task automatic addr_ph(input logic [7:0] a, input logic w);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a; HREADY = 1'b1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge HCLK); addr_ph(a, 1'b1);
      @(negedge HCLK); idle(); HWDATA = d;
      @(negedge HCLK);
   endtask

   task automatic rdr(input logic [7:0] a, output logic [31:0] d);
      @(negedge HCLK); addr_ph(a, 1'b0);
      @(negedge HCLK); idle(); d = HRDATA;
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) m_sel[i] = 2'd0;
   endtask

   initial begin
      HRESETn = 1'b0; idle(); HWDATA = '0; io_in = '0;
      for (int k = 0; k < 5; k++) rnd[k*32 +: 32] = $urandom;
      fn_out = rnd[4*N-1:0];
      for (int k = 0; k < 5; k++) rnd[k*32 +: 32] = $urandom;
      fn_oeb = rnd[4*N-1:0];
      model_clear();

      // Reset state
      repeat (2) @(negedge HCLK);
      chk("rst_io_out_in_reset", io_out, fn_out[N-1:0]);
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("rst_io_out", io_out, fn_out[N-1:0]);
      chk("rst_io_oeb", io_oeb, fn_oeb[N-1:0]);
      chk("idle_hrdata", HRDATA, 0);
      chk("hreadyout", HREADYOUT, 1);
      chk("hresp", HRESP, 0);
      rdr(8'h00, rd); chk("rst_sel0", rd, 0);

      // Pad 21 -> function 2 (SEL1 bits 11:10)
      wr(8'h04, 32'h0000_0800); m_sel[21] = 2'd2;
      chk("p21_out", io_out[21], fn_out[2*N+21]);
      chk("p21_oeb", io_oeb[21], fn_oeb[2*N+21]);
      chk("p21_full_out", io_out, exp_pad(fn_out));
      fn_out = ~fn_out; #1;
      chk("p21_out_follow", io_out[21], fn_out[2*N+21]);
      chk("p21_full_oeb", io_oeb, exp_pad(fn_oeb));
      io_in[21] = 1'b1; io_in[20] = 1'b0; #1;
      chk("p21_fn2_in_hi", fn_in[2*N+21], 1);
      io_in[21] = 1'b0; #1;
      chk("p21_fn2_in_lo", fn_in[2*N+21], 0);
      chk("p21_fn0_idle", fn_in[21], 1);
      chk("p21_fn1_idle", fn_in[N+21], 1);
      chk("p20_fn0_in", fn_in[20], 0);
      rdr(8'h04, rd); chk("sel1_read", rd, 32'h0000_0800);

      // SEL2: only pads 32..37 exist, then back-to-back write/read
      wr(8'h08, 32'hFFFF_FFFF);
      rdr(8'h08, rd); chk("sel2_upper_zero", rd, 32'h0000_0FFF);
      @(negedge HCLK); addr_ph(8'h08, 1'b1);
      @(negedge HCLK); HWDATA = 32'h5; addr_ph(8'h08, 1'b0);
      @(negedge HCLK); idle(); rd = HRDATA;
      chk("b2b_sel2", rd, 32'h0000_0005);
      m_sel[32] = 2'd1; m_sel[33] = 2'd1;
      chk("sel2_io_out", io_out, exp_pad(fn_out));

      // SEL3 (no pads) and unmapped space
      wr(8'h0C, 32'hFFFF_FFFF);
      rdr(8'h0C, rd); chk("sel3_empty", rd, 0);
      wr(8'h20, 32'hFFFF_FFFF);
      rdr(8'h20, rd); chk("unmapped_read", rd, 0);
      rdr(8'h00, rd); chk("unmapped_no_alias", rd, 0);

      // Address phases without HTRANS[1] or HREADY must be ignored
      @(negedge HCLK); HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 8'h00;
      @(negedge HCLK); idle(); HWDATA = 32'hFFFF_FFFF;
      @(negedge HCLK); addr_ph(8'h00, 1'b1); HREADY = 1'b0;
      @(negedge HCLK); idle(); HWDATA = 32'hFFFF_FFFF;
      rdr(8'h00, rd); chk("no_capture", rd, 0);

`ifdef PINMUX_LOCK_EN
      wr(8'h00, 32'h1);
      wr(8'h10, 32'h1);
      rdr(8'h10, rd); chk("lock_set", rd, 1);
      wr(8'h10, 32'h0);
      rdr(8'h10, rd); chk("lock_sticky", rd, 1);
      wr(8'h00, 32'hFFFF_FFFF);
      rdr(8'h00, rd); chk("lock_sel0_frozen", rd, 1);
      @(negedge HCLK); HRESETn = 1'b0;
      @(negedge HCLK); HRESETn = 1'b1;
      model_clear();
      rdr(8'h10, rd); chk("lock_after_reset", rd, 0);
`else
      wr(8'h10, 32'h1);
      rdr(8'h10, rd); chk("lock_absent", rd, 0);
`endif
      wr(8'h00, 32'h2); m_sel[0] = 2'd2;
      rdr(8'h00, rd); chk("sel0_writable", rd, 2);
      chk("sel0_io_out", io_out, exp_pad(fn_out));

      // PADIN two-cycle latency
      io_in = '0;
      repeat (3) @(negedge HCLK);
      @(negedge HCLK); io_in = 38'h2A_AAAA_AAAA; addr_ph(8'h14, 1'b0);
      @(negedge HCLK); rd = HRDATA; addr_ph(8'h14, 1'b0);
      chk("padin_t1_old", rd, 0);
      @(negedge HCLK); rd = HRDATA; addr_ph(8'h18, 1'b0);
      chk("padin_t2_lo", rd, 32'hAAAA_AAAA);
      @(negedge HCLK); rd = HRDATA; idle();
      chk("padin_t2_hi", rd, 32'h0000_002A);

      // Reset asserted during a SEL0 data-phase write
      @(negedge HCLK); addr_ph(8'h00, 1'b1);
      @(negedge HCLK); idle(); HWDATA = 32'h3;
      #2 HRESETn = 1'b0;
      #1 chk("rst_mid_io_out0", io_out[0], fn_out[0]);
      model_clear();
      chk("rst_mid_io_out", io_out, fn_out[N-1:0]);
      @(negedge HCLK); @(negedge HCLK); HRESETn = 1'b1;
      rdr(8'h00, rd); chk("rst_mid_sel0", rd, 0);
      chk("rst_mid_after_out0", io_out[0], fn_out[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
